// File: rtl/cbrt_arbiter_if.sv
// Bus between the cbrt arbiter, its requesters and the shared cbrt unit.
// slave = arbiter side, master = environment (requesters plus cbrt unit).
interface cbrt_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    // Handshake: requester i raises req_valid[i] with req_x stable and holds both until
    // req_ready[i] pulses for one cycle (the accept). resp_valid is a one-cycle pulse with
    // no backpressure. The cbrt unit gets a one-cycle cbrt_start, raises cbrt_busy while
    // working, and cbrt_result is valid once cbrt_busy is low again.
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_x;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic [IDW-1:0]     resp_id;
    logic [15:0]        resp_data;
    logic               arb_busy;
    logic [15:0]        cbrt_x;
    logic               cbrt_start;
    logic               cbrt_busy;
    logic [15:0]        cbrt_result;

    modport slave (
        input  req_valid, req_x, cbrt_busy, cbrt_result,
        output req_ready, resp_valid, resp_id, resp_data, arb_busy, cbrt_x, cbrt_start
    );

    modport master (
        output req_valid, req_x, cbrt_busy, cbrt_result,
        input  req_ready, resp_valid, resp_id, resp_data, arb_busy, cbrt_x, cbrt_start
    );
endinterface

// File: rtl/cbrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one cbrt unit among NREQ requesters.
// Optional macro CBRT_ARB_BYPASS_EN adds a one-entry (x, result) cache that skips cbrt on a repeat operand.
module cbrt_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    cbrt_arbiter_if.slave bus,
    output logic [2:0]    o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_ptr_next;
    logic [15:0]     r_x;
    logic [15:0]     r_result;
    logic [15:0]     w_sel_x;
    logic [15:0]     w_cache_res;
    logic [NREQ-1:0] w_ready;
    logic            r_wait_cnt;
    logic            w_any;
    logic            w_accept;
    logic            w_capture;
    logic            w_hit;

    // Scan from rr_ptr upward with wrap; iterating from the far end lets the nearest hit win.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (bus.req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_x = '0;
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_sel_x = bus.req_x[16*i +: 16];
            end
            w_ready[i] = (r_state == S_IDLE) && w_any && (w_winner == IDW'(i));
        end
    end

    assign w_ptr_next = (int'(w_winner) == NREQ - 1) ? '0 : w_winner + IDW'(1);

`ifdef CBRT_ARB_BYPASS_EN
    logic        r_cache_vld;
    logic [15:0] r_cache_x;
    logic [15:0] r_cache_res;

    assign w_hit       = r_cache_vld && (w_sel_x == r_cache_x);
    assign w_cache_res = r_cache_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld <= 1'b0;
            r_cache_x   <= '0;
            r_cache_res <= '0;
        end else if (w_capture) begin
            r_cache_vld <= 1'b1;
            r_cache_x   <= r_x;
            r_cache_res <= bus.cbrt_result;
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_cache_res = '0;
`endif

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = w_hit ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT_BUSY;
            // Second cycle without busy means the start was missed; carry on regardless.
            S_WAIT_BUSY: begin
                if (bus.cbrt_busy || r_wait_cnt) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.cbrt_busy) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_x        <= '0;
            r_id       <= '0;
            r_result   <= '0;
            r_wait_cnt <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= (r_state == S_WAIT_BUSY);
            if (w_accept) begin
                r_x      <= w_sel_x;
                r_id     <= w_winner;
                r_rr_ptr <= w_ptr_next;
            end
            if (w_capture) begin
                r_result <= bus.cbrt_result;
            end else if (w_accept && w_hit) begin
                r_result <= w_cache_res;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_id    = r_id;
    assign bus.resp_data  = r_result;
    assign bus.arb_busy   = (r_state != S_IDLE);
    assign bus.cbrt_x     = r_x;
    assign bus.cbrt_start = (r_state == S_ISSUE);
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_cbrt_arbiter.sv
// Self-checking bench for cbrt_arbiter with a behavioural cbrt unit and a response scoreboard.
module tb_cbrt_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = IDW + 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_fail = 0;

    cbrt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

    cbrt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_cbrt(input logic [15:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(x)) r++;
        return 16'(r);
    endfunction

    // Behavioural cbrt: busy for stub_lat cycles after start, garbage result while busy.
    int          stub_lat = 3;
    bit          stub_drop = 1'b0;
    int          stub_cnt;
    logic [15:0] stub_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cbrt_busy   <= 1'b0;
            bus.cbrt_result <= '0;
            stub_cnt        <= 0;
        end else if (bus.cbrt_start) begin
            if (stub_drop) begin
                bus.cbrt_result <= ref_cbrt(bus.cbrt_x);
            end else begin
                bus.cbrt_busy   <= 1'b1;
                bus.cbrt_result <= 16'hBEEF;
                stub_cnt        <= stub_lat - 1;
                stub_res        <= ref_cbrt(bus.cbrt_x);
            end
        end else if (bus.cbrt_busy) begin
            if (stub_cnt == 0) begin
                bus.cbrt_busy   <= 1'b0;
                bus.cbrt_result <= stub_res;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Event logs and scoreboard
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    got_q[$];
    int              grant_q[$];
    int              acc_cyc_q[$];
    int              resp_cyc_q[$];
    int              start_cyc_q[$];
    int              cyc = 0;
    int              n_start = 0;
    int              onehot_bad = 0;
    int              ready_busy = 0;
    logic [NREQ-1:0] ready_seen = '0;
    bit              auto_drop = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (bus.cbrt_start) begin
            n_start++;
            start_cyc_q.push_back(cyc);
        end
        ready_seen = bus.req_ready;
        if (bus.req_ready != '0) begin
            if ($countones(bus.req_ready) != 1) onehot_bad++;
            if (bus.arb_busy) ready_busy++;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grant_q.push_back(i);
            acc_cyc_q.push_back(cyc);
        end
        if (bus.resp_valid) begin
            got_q.push_back({bus.resp_id, bus.resp_data});
            resp_cyc_q.push_back(cyc);
        end
    end

    // Requesters drop their valid right after being accepted unless told to hold it.
    always @(posedge clk) begin
        #1;
        if (auto_drop) bus.req_valid = bus.req_valid & ~ready_seen;
    end

    // Driver tasks
    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); grant_q.delete();
        acc_cyc_q.delete(); resp_cyc_q.delete(); start_cyc_q.delete();
        n_start = 0; onehot_bad = 0; ready_busy = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic set_req(input int i, input logic [15:0] x);
        bus.req_x[16*i +: 16] = x;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_resps(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_x = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.arb_busy, bus.cbrt_start, bus.resp_valid, bus.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b start=%b resp_valid=%b ready=%b, required all 0",
                     bus.arb_busy, bus.cbrt_start, bus.resp_valid, bus.req_ready);
        end
        n_checks++;
        if ({bus.resp_id, bus.resp_data, bus.cbrt_x, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: id=%0d data=%0d cbrt_x=%0d state=%0d, required all 0",
                     bus.resp_id, bus.resp_data, bus.cbrt_x, dbg_state);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [W-1:0] e, g;
        do_reset();
        stub_lat = 3;
        @(posedge clk); #1;
        set_req(0, 16'd27);
        exp_q.push_back({IDW'(0), 16'd3});
        wait_resps(1, 100);
        n_checks++;
        if (grant_q.size() != 1 || grant_q[0] != 0) begin
            n_fail++;
            $display("FAIL single_grant: %0d grant cycles (first %0d), required 1 grant to 0", grant_q.size(), grant_q.size() > 0 ? grant_q[0] : -1);
        end
        n_checks++;
        if (n_start != 1) begin
            n_fail++; $display("FAIL single_starts: %0d cbrt_start pulses, required 1", n_start);
        end
        n_checks++;
        if (start_cyc_q.size() != 1 || acc_cyc_q.size() != 1 || start_cyc_q[0] != acc_cyc_q[0] + 1) begin
            n_fail++; $display("FAIL single_start_lat: start not exactly one cycle after accept");
        end
        n_checks++;
        if (resp_cyc_q.size() != 1 || start_cyc_q.size() != 1 || resp_cyc_q[0] != start_cyc_q[0] + 5) begin
            n_fail++; $display("FAIL single_resp_lat: resp not at start+5 (busy falls at start+4)");
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_count: %0d responses, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL single_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'd3 || bus.resp_id !== IDW'(0)) begin
            n_fail++; $display("FAIL single_hold: valid=%b data=%0d id=%0d, required 0/3/0", bus.resp_valid, bus.resp_data, bus.resp_id);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] e, g;
        logic [15:0] xs[4] = '{16'd64, 16'd1000, 16'd0, 16'd65535};
        logic [15:0] rs[4] = '{16'd4, 16'd10, 16'd0, 16'd40};
        do_reset();
        stub_lat = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, xs[i]);
            exp_q.push_back({IDW'(i), rs[i]});
        end
        wait_resps(4, 200);
        n_checks++;
        if (grant_q.size() != 4) begin
            n_fail++; $display("FAIL simul_grant_count: %0d grants, required 4", grant_q.size());
        end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            n_checks++;
            if (grant_q[i] != i) begin
                n_fail++; $display("FAIL simul_order: grant %0d went to %0d, required %0d", i, grant_q[i], i);
            end
        end
        n_checks++;
        if (n_start != 4 || onehot_bad != 0 || ready_busy != 0) begin
            n_fail++; $display("FAIL simul_starts: starts=%0d onehot_bad=%0d ready_busy=%0d, required 4/0/0", n_start, onehot_bad, ready_busy);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL simul_count: %0d responses, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL simul_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [W-1:0] e, g;
        int k = 0;
        do_reset();
        stub_lat = 1;
        auto_drop = 1'b0;
        @(posedge clk); #1;
        set_req(1, 16'd1000);
        set_req(3, 16'd343);
        while (grant_q.size() < 6 && k < 300) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus.req_valid = '0;
        auto_drop = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? {IDW'(1), 16'd10} : {IDW'(3), 16'd7});
        wait_resps(6, 200);
        n_checks++;
        if (grant_q.size() != 6) begin
            n_fail++; $display("FAIL fair_count: %0d grants, required 6", grant_q.size());
        end
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            n_checks++;
            if (grant_q[i] != ((i % 2 == 0) ? 1 : 3)) begin
                n_fail++; $display("FAIL fair_order: grant %0d went to %0d, required %0d", i, grant_q[i], (i % 2 == 0) ? 1 : 3);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL fair_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, g;
        int k = 0;
        do_reset();
        stub_lat = 2;
        auto_drop = 1'b0;
        @(posedge clk); #1;
        set_req(2, 16'd200);
        while (grant_q.size() < 3 && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus.req_valid = '0;
        auto_drop = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({IDW'(2), 16'd5});
        wait_resps(3, 200);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (acc_cyc_q.size() != 3 || resp_cyc_q.size() != 3 || acc_cyc_q[i+1] != resp_cyc_q[i] + 1) begin
                n_fail++; $display("FAIL b2b_regrant: op %0d re-grant not in the IDLE cycle right after RESP", i);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL b2b_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    task automatic test_missed_start();
        logic [W-1:0] e, g;
        do_reset();
        stub_drop = 1'b1;
        @(posedge clk); #1;
        set_req(1, 16'd4096);
        exp_q.push_back({IDW'(1), 16'd16});
        wait_resps(1, 100);
        stub_drop = 1'b0;
        n_checks++;
        if (resp_cyc_q.size() != 1 || start_cyc_q.size() != 1 || resp_cyc_q[0] != start_cyc_q[0] + 4) begin
            n_fail++; $display("FAIL missed_lat: no busy should give resp at start+4 (%0d resps, %0d starts)", resp_cyc_q.size(), start_cyc_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL missed_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] e, g;
        int k = 0;
        do_reset();
        stub_lat = 8;
        @(posedge clk); #1;
        set_req(3, 16'd1331);
        while (dbg_state !== 3'd3 && k < 50) begin @(negedge clk); k++; end
        n_checks++;
        if (dbg_state !== 3'd3) begin
            n_fail++; $display("FAIL midop_reach: state=%0d after %0d cycles, required WAIT_DONE(3)", dbg_state, k);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.arb_busy, bus.cbrt_start, bus.resp_valid, bus.req_ready, bus.cbrt_x, bus.resp_id, bus.resp_data} !== '0) begin
            n_fail++; $display("FAIL midop_outputs: busy=%b cbrt_x=%0d resp_valid=%b, required all 0", bus.arb_busy, bus.cbrt_x, bus.resp_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0 || n_start != 1) begin
            n_fail++; $display("FAIL midop_abort: %0d responses and %0d starts, required 0 and 1", got_q.size(), n_start);
        end
        got_q.delete();
        @(posedge clk); #1;
        set_req(1, 16'd8);
        exp_q.push_back({IDW'(1), 16'd2});
        wait_resps(1, 100);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL midop_after_count: %0d responses, required 1", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL midop_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    task automatic test_idle();
        bus.req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.arb_busy !== 1'b0 || bus.cbrt_start !== 1'b0 || bus.req_ready !== '0) begin
                n_fail++; $display("FAIL idle_quiet: cycle %0d busy=%b start=%b ready=%b, required all 0", i, bus.arb_busy, bus.cbrt_start, bus.req_ready);
            end
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] e, g;
        int s0;
        do_reset();
        stub_lat = 3;
        @(posedge clk); #1;
        set_req(2, 16'd125);
        exp_q.push_back({IDW'(2), 16'd5});
        wait_resps(1, 100);
        s0 = n_start;
        @(posedge clk); #1;
        set_req(0, 16'd125);
        exp_q.push_back({IDW'(0), 16'd5});
        wait_resps(2, 100);
`ifdef CBRT_ARB_BYPASS_EN
        n_checks++;
        if (n_start != s0 || resp_cyc_q.size() != 2 || acc_cyc_q.size() != 2 || resp_cyc_q[1] != acc_cyc_q[1] + 1) begin
            n_fail++; $display("FAIL bypass_hit: starts %0d->%0d, required no new start and resp one cycle after accept", s0, n_start);
        end
`else
        n_checks++;
        if (n_start != s0 + 1 || resp_cyc_q.size() != 2 || start_cyc_q.size() != 2 || resp_cyc_q[1] != start_cyc_q[1] + 5) begin
            n_fail++; $display("FAIL bypass_off: starts %0d->%0d, required one new full cbrt sequence", s0, n_start);
        end
`endif
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL bypass_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e, g;
        int i;
        logic [15:0] x;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            i = $urandom_range(0, NREQ - 1);
            x = 16'($urandom_range(0, 65535));
            stub_lat = $urandom_range(1, 5);
            @(posedge clk); #1;
            set_req(i, x);
            exp_q.push_back({IDW'(i), ref_cbrt(x)});
            wait_resps(n + 1, 100);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random_count: %0d responses, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL random_resp: id=%0d data=%0d, required id=%0d data=%0d", g[W-1:16], g[15:0], e[W-1:16], e[15:0]);
            end
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_back_to_back();
        test_missed_start();
        test_reset_midop();
        test_idle();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
